// File: rtl/alsu_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : alsu_cmd_seq
// Purpose  : Command sequencer in front of the ALSU. Buffers packed command
//            words in a DEPTH-entry FIFO, issues one command per cycle to the
//            ALSU control/operand inputs, optionally re-issues a command
//            back-to-back (rep field) and flags when the ALSU registered
//            output holds the result of an issued command.
// Config   : `ALSU_SEQ_REPEAT_EN - when defined the rep field [18:16] is
//            honoured; otherwise every command issues exactly once.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cmd_valid/cmd_ready - upstream handshake, cmd_data [18:0]
//            flush               - drop queued and in-flight work
//            A, B, opc, cin, sin, dir, ropA, ropB, bpA, bpB - to ALSU
//            iss_valid           - outputs carry a real command
//            res_valid           - ALSU out holds an issued result
//            count               - FIFO occupancy
//            busy                - any work queued, issuing or in flight
// Revision : 1.0 - initial release
// ============================================================================
module alsu_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int CW    = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CW-1:0]              cmd_data,
  input  logic                       flush,
  output logic [2:0]                 A,
  output logic [2:0]                 B,
  output logic [2:0]                 opc,
  output logic                       cin,
  output logic                       sin,
  output logic                       dir,
  output logic                       ropA,
  output logic                       ropB,
  output logic                       bpA,
  output logic                       bpB,
  output logic                       iss_valid,
  output logic                       res_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] C_DEPTH = NW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] count_q, count_d;
  logic [15:0]   ctl_q, ctl_d;     // ALSU control/operand bundle, cmd_data[15:0]
  logic          iss_q, iss_d;
  logic [1:0]    res_q;            // iss_valid delayed by ALSU in+out registers
  logic          w_push, w_load, w_rep_zero, w_nonempty;
  logic [CW-1:0] w_head;

  assign w_nonempty = (count_q != '0);
  // No push-through: readiness depends only on the registered occupancy.
  assign cmd_ready  = (count_q < C_DEPTH);
  assign w_push     = cmd_valid & cmd_ready & ~flush;
  assign w_head     = mem_q[rd_q];

`ifdef ALSU_SEQ_REPEAT_EN
  logic [2:0] rep_q, rep_d;

  assign w_rep_zero = (rep_q == 3'd0);

  always_comb begin
    rep_d = rep_q;
    if (w_load) begin
      rep_d = w_head[18:16];
    end else if (!w_rep_zero) begin
      rep_d = rep_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      rep_q <= 3'd0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  // rep bits are stored with the word but never acted upon.
  logic [2:0] w_unused_rep;
  assign w_unused_rep = w_head[18:16];
  assign w_rep_zero   = 1'b1;
`endif

  // Issue stage: a new head is loaded whenever no repeat is pending, so
  // consecutive commands issue with no bubble.
  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    iss_d   = 1'b0;
    ctl_d   = ctl_q;
    case (state_q)
      S_IDLE: begin
        if (w_nonempty) w_load = 1'b1;
      end
      S_ISSUE: begin
        if (!w_rep_zero) begin
          iss_d = 1'b1;
        end else if (w_nonempty) begin
          w_load = 1'b1;
        end
      end
      default: ;
    endcase
    if (w_load) begin
      iss_d = 1'b1;
      ctl_d = w_head[15:0];
    end
    // Idle cycles present all-zero controls to the ALSU.
    if (!iss_d) ctl_d = '0;
    state_d = iss_d ? S_ISSUE : S_IDLE;
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_load})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ctl_q   <= '0;
      iss_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (w_push) wr_q <= wr_q + PW'(1);
      if (w_load) rd_q <= rd_q + PW'(1);
      count_q <= count_d;
      ctl_q   <= ctl_d;
      iss_q   <= iss_d;
      res_q   <= {res_q[0], iss_q};
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= cmd_data;
  end

  assign A         = ctl_q[2:0];
  assign B         = ctl_q[5:3];
  assign opc       = ctl_q[8:6];
  assign cin       = ctl_q[9];
  assign sin       = ctl_q[10];
  assign dir       = ctl_q[11];
  assign ropA      = ctl_q[12];
  assign ropB      = ctl_q[13];
  assign bpA       = ctl_q[14];
  assign bpB       = ctl_q[15];
  assign iss_valid = iss_q;
  assign res_valid = res_q[1];
  assign count     = count_q;
  assign busy      = iss_q | w_nonempty | (|res_q);

endmodule
`default_nettype wire

// File: doc/alsu_cmd_seq.md
# alsu_cmd_seq

Command sequencer that sits directly upstream of the ALSU. It accepts packed ALSU command words over a valid/ready handshake and buffers them in a small FIFO. It drives the ALSU operand and control inputs one command per cycle, optionally re-issuing a command N times back-to-back for shift and rotate chains. It also emits a `res_valid` strobe aligned with the ALSU's registered `out`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, ≥2.
- `CW`, 19: command word width. Fixed; present for readability only.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `cmd_valid` in 1: upstream command present.
- `cmd_ready` out 1: FIFO can accept. Equals `count < DEPTH`.
- `cmd_data` in 19: bit fields below.
  - [2:0] A
  - [5:3] B
  - [8:6] opc
  - [9] cin
  - [10] sin
  - [11] dir
  - [12] ropA
  - [13] ropB
  - [14] bpA
  - [15] bpB
  - [18:16] rep
- `flush` in 1: drop all queued and in-flight work.
- `A`, `B`, `opc` out 3 each: to ALSU.
- `cin`, `sin`, `dir`, `ropA`, `ropB`, `bpA`, `bpB` out 1 each: to ALSU.
- `iss_valid` out 1: outputs carry a real command this cycle.
- `res_valid` out 1: ALSU `out` holds the result of an issued command this cycle.
- `count` out clog2(DEPTH+1): FIFO occupancy.
- `busy` out 1: `iss_valid | (count != 0) | any res pipeline bit set`.

## Operation
- **FIFO:** push on `cmd_valid & cmd_ready`. Pop when the issue stage loads a new command. Wrap pointers modulo DEPTH; count is separate.
  - Push and pop in the same cycle leave `count` unchanged.
  - When full, `cmd_ready` = 0 even if a pop occurs that cycle (no push-through).
- **State machine:** two states, IDLE and ISSUE.
  - IDLE → ISSUE when `count != 0`. The head word is loaded into the output registers, `iss_valid` = 1, and `rep_cnt` ← rep.
  - ISSUE with `rep_cnt != 0`: hold the same outputs, `iss_valid` = 1, `rep_cnt` decrements.
  - ISSUE with `rep_cnt == 0` and `count != 0`: load the next head back-to-back, with no bubble.
  - ISSUE with `rep_cnt == 0` and `count == 0`: go to IDLE.
- **Idle outputs:** all ALSU outputs are 0 and `iss_valid` = 0. The ALSU then computes A&B = 0, so its shift/rotate state is not preserved across idle gaps. Use `rep` for chains.
- **Result tracking:** `res_valid` is `iss_valid` delayed by exactly 2 cycles through a 2-bit shift pipeline. This matches the ALSU input register plus output register.
- **Flush:**
  - Next edge: pointers, `count`, `rep_cnt` and the res pipeline clear, state goes to IDLE, outputs go to 0.
  - A push in the flush cycle is discarded.
  - Flush has priority over push and pop.
- **Reset:** same effect as flush.
  - `cmd_ready` = 1.
  - `count` = 0.
  - `iss_valid` = 0 and `res_valid` = 0.
  - All ALSU outputs = 0.
  - `busy` = 0.
  - State IDLE.

## Timing
- Push at edge t: earliest issue registered at edge t+1 (`iss_valid` high in cycle t+1). Matching `res_valid` is high in cycle t+3.
- Sustained throughput: one issue per cycle while the FIFO is non-empty.
- A command with rep = r occupies r+1 consecutive issue cycles and produces r+1 consecutive `res_valid` pulses.
- Reset or flush asserted mid-repeat: the remainder is cancelled. Any `res_valid` that would fire at or after the edge following reset or flush is suppressed.
- All outputs are registered; there are no combinational input-to-output paths except `cmd_ready` from `count`.

## Configuration
- `ALSU_SEQ_REPEAT_EN` defined: the rep field is honoured as described above.
- Not defined:
  - rep bits are ignored and every command issues exactly once.
  - `rep_cnt` logic is not built.
  - cmd_data[18:16] must still be accepted and stored or dropped silently; behaviour must be identical to rep = 0.

## Test plan
- **Reset:** assert `rst` 2 cycles with `cmd_valid` = 1. Expect `count` = 0, all outputs 0, `cmd_ready` = 1, no `res_valid`.
- **Single command:** push A=3, B=2, opc=010, cin=1 at edge t. Expect `iss_valid` in cycle t+1 and `res_valid` in t+3 with ALSU `out` = 6.
- **Full FIFO:**
  - Hold the issue stage busy with a rep=7 command and push DEPTH more.
  - Expect `cmd_ready` = 0 at `count` = 8, with the 9th push held off.
  - Expect all 8 to issue back-to-back in order.
- **Repeat shift:** push opc=100, dir=1, sin=1, rep=5, with `ALSU_SEQ_REPEAT_EN` defined. Expect 6 `iss_valid` cycles and ALSU `out` = 6'b111111 on the last `res_valid`. With the macro undefined, expect one issue only.
- **Flush mid-repeat:** assert `flush` in the 2nd of 6 repeat cycles with 3 queued. Expect outputs 0 next cycle, `count` = 0, no further `res_valid`, and `busy` = 0.
- **Simultaneous push/pop:** at `count` = 4, push while the issue stage loads the next command. Expect `count` to stay 4 and command order to be preserved.
